fpga_cfg_loader: RTL
====================

Name: fpga_cfg_loader

Overview:
- Parametrised configuration loader for the custom FPGA fabric.
- Accepts a serial or narrow-parallel bitstream on top-level pins, shifts it into a shadow register, and verifies a trailing XOR checksum.
- Commits the shadow register atomically to the active configuration only if the checksum matches.
- Sits between the top-level pin wrapper and the fabric. The fabric keeps running on the old configuration while a new one loads (double-buffered reconfiguration).

Parameters:
- DIN_W, 1, bits accepted per beat; legal values 1, 2, 4, 8.
- CFG_BITS, 256, configuration length in bits; must be a multiple of 8 and of DIN_W.
- Derived local constants, not overridable:
  - BEATS = CFG_BITS/DIN_W.
  - CK_BEATS = 8/DIN_W.
  - CNT_W = clog2(BEATS+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  single-cycle pulse; begins a new load
- cfg_abort  in  1  abandons the load in progress
- cfg_valid  in  1  cfg_data holds a valid beat
- cfg_data  in  DIN_W  bitstream beat; bit DIN_W-1 is the earliest in stream order
- cfg_ready  out  1  loader accepts beats
- cfg_bits  out  CFG_BITS  active configuration driven to the fabric
- fabric_en  out  1  fabric may run; cfg_bits is valid
- cfg_done  out  1  the last load committed successfully
- cfg_err  out  1  the last load failed its checksum
- cfg_busy  out  1  a load is in progress

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values: all outputs 0, including cfg_bits. State is IDLE; shadow register, beat counter and checksum accumulator are all 0.
- A beat transfers when cfg_valid && cfg_ready at a rising edge.
- cfg_ready is 1 exactly in LOAD and CHECK. It is a registered function of state, with no combinational path from cfg_valid.
- cfg_busy = (state is LOAD or CHECK).
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + cfg_start -> LOAD:
  - Clear shadow, counter and accumulator.
  - Clear cfg_done and cfg_err.
  - cfg_bits and fabric_en are unchanged.
- LOAD, per transfer:
  - shadow <= {shadow[CFG_BITS-DIN_W-1:0], cfg_data}, so the first stream bit ends at cfg_bits MSB.
  - Update the accumulator and increment the counter.
  - On the BEATS-th transfer, go to CHECK and clear the counter.
- Checksum definition: the XOR of all CFG_BITS/8 stream bytes. Byte k is stream bits 8k..8k+7, and the earliest bit of each byte is its MSB.
- CHECK collects CK_BEATS beats forming the expected checksum byte, MSB first. On the last beat, compare it to the accumulator:
  - Match: cfg_bits <= shadow in that same edge; fabric_en <= 1; cfg_done <= 1; go to DONE.
  - Mismatch: cfg_err <= 1; go to ERROR. cfg_bits and fabric_en are untouched.
- cfg_abort in LOAD or CHECK -> IDLE: discard the shadow, leave cfg_done/cfg_err at 0, leave cfg_bits and fabric_en untouched. cfg_abort in any other state is ignored.
- Simultaneous events:
  - cfg_start and cfg_abort together: cfg_abort wins.
  - cfg_start while in LOAD or CHECK: ignored.
  - A transfer in the same cycle as cfg_abort: discarded.
- The stream has no idle-gap limit: cfg_valid low stalls indefinitely.
- Reset mid-load: everything returns to reset values, and fabric_en drops to 0.
- cfg_bits changes only on a successful commit or on reset, never partially.

Decomposition:
- Shared package fpga_cfg_pkg holds:
  - the state enum;
  - the legal DIN_W set and the CFG_BITS divisibility assertions;
  - a clog2 function.
- One sub-module, fpga_cfg_xor8: a byte-aligned XOR accumulator fed DIN_W bits per beat. Its ports are clear, enable, din[DIN_W] and sum[8].

Test Plan:
- Nominal load, DIN_W=1, CFG_BITS=16: stream 0xA5, 0x3C, then checksum 0x99 -> cfg_bits=0xA53C, fabric_en=1, cfg_done=1, cfg_err=0. cfg_busy is high for 24 accepted beats.
- Bad checksum, same stream with checksum 0x98 -> cfg_err=1, cfg_done=0, state ERROR, cfg_bits unchanged.
- Reload while running: after the 0xA53C commit, load 0x1234 with checksum 0x26 -> cfg_bits stays 0xA53C until the edge of the final checksum beat, then becomes 0x1234. fabric_en never drops.
- Stalls and abort, DIN_W=4, CFG_BITS=16: random cfg_valid gaps still load 0xBEEF with checksum 0x51. A second load with cfg_abort after beat 2 -> IDLE and cfg_bits=0xBEEF; cfg_start together with cfg_abort -> abort wins.
- Async reset mid-load: assert rst_n low between clock edges during beat 5 -> all outputs 0 immediately. A following load of 0xA53C (checksum 0x99) succeeds.
- Parameter sweep: DIN_W in {1,2,4,8} with CFG_BITS=256 and random streams -> cfg_bits matches the model and the checksum matches the reference XOR.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and elaboration helpers for the configuration loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } cfg_state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Beat width must divide a byte evenly.
  function automatic bit din_w_legal(input int unsigned w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

  // Configuration length must be whole bytes and whole beats.
  function automatic bit cfg_bits_legal(input int unsigned bits, input int unsigned w);
    return (bits > 0) && (w > 0) && ((bits % 8) == 0) && ((bits % w) == 0);
  endfunction

endpackage

// File: rtl/fpga_cfg_xor8.sv
// Byte-aligned XOR accumulator: DIN_W-bit beats are placed into byte lanes
// MSB-first and folded into an 8-bit running checksum.
module fpga_cfg_xor8 #(
  parameter int DIN_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIN_W-1:0] din,
  output logic [7:0]       sum
);

  localparam int CK_BEATS = 8 / DIN_W;

  logic [2:0] lane;
  logic [7:0] placed;
  logic       lane_wrap;

  // Position the incoming beat at its lane within the current byte.
  always_comb begin
    placed    = '0;
    lane_wrap = (lane == 3'(CK_BEATS - 1));
    for (int unsigned i = 0; i < CK_BEATS; i++) begin
      if (lane == 3'(i)) placed[7 - i*DIN_W -: DIN_W] = din;
    end
  end

  // Fold placed beats into the checksum; lane pointer wraps per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      lane <= '0;
    end else if (clear) begin
      sum  <= '0;
      lane <= '0;
    end else if (enable) begin
      sum  <= sum ^ placed;
      lane <= lane_wrap ? 3'd0 : lane + 3'd1;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Double-buffered configuration loader: shifts a bitstream into a shadow
// register, checks a trailing XOR byte, and commits atomically on match.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int DIN_W    = 1,
  parameter int CFG_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic                cfg_valid,
  input  logic [DIN_W-1:0]    cfg_data,
  output logic                cfg_ready,
  output logic [CFG_BITS-1:0] cfg_bits,
  output logic                fabric_en,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                cfg_busy
);

  localparam int BEATS    = CFG_BITS / DIN_W;
  localparam int CK_BEATS = 8 / DIN_W;
  localparam int CNT_W    = clog2(BEATS + 1);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CK_LAST   = CNT_W'(CK_BEATS - 1);

  if (!din_w_legal(DIN_W)) begin : g_bad_din_w
    $error("fpga_cfg_loader: DIN_W must be 1, 2, 4 or 8");
  end
  if (!cfg_bits_legal(CFG_BITS, DIN_W)) begin : g_bad_cfg_bits
    $error("fpga_cfg_loader: CFG_BITS must be a multiple of 8 and of DIN_W");
  end

  cfg_state_t          state;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] shadow_next;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          ck_byte;
  logic [7:0]          ck_next;
  logic [7:0]          acc_sum;
  logic                xfer;
  logic                start_ok;
  logic                acc_en;

  // Shift-in paths; a single-beat register degenerates to a plain load.
  if (CFG_BITS > DIN_W) begin : g_shadow_shift
    assign shadow_next = {shadow[CFG_BITS-DIN_W-1:0], cfg_data};
  end else begin : g_shadow_load
    assign shadow_next = cfg_data;
  end

  if (DIN_W < 8) begin : g_ck_shift
    assign ck_next = {ck_byte[7-DIN_W:0], cfg_data};
  end else begin : g_ck_load
    assign ck_next = cfg_data;
  end

  // Transfer/start qualification; abort always takes priority.
  always_comb begin
    xfer     = cfg_valid && cfg_ready && !cfg_abort;
    start_ok = cfg_start && !cfg_abort &&
               ((state == IDLE) || (state == DONE) || (state == ERROR));
    acc_en   = xfer && (state == LOAD);
  end

  fpga_cfg_xor8 #(
    .DIN_W (DIN_W)
  ) u_xor8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_ok),
    .enable (acc_en),
    .din    (cfg_data),
    .sum    (acc_sum)
  );

  // Load sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      ck_byte   <= '0;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_bits  <= '0;
      fabric_en <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_ok) begin
            state     <= LOAD;
            shadow    <= '0;
            cnt       <= '0;
            ck_byte   <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_abort) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
          end else if (xfer) begin
            shadow <= shadow_next;
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= CHECK;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (cfg_abort) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
          end else if (xfer) begin
            ck_byte <= ck_next;
            if (cnt == CK_LAST) begin
              cnt       <= '0;
              cfg_ready <= 1'b0;
              cfg_busy  <= 1'b0;
              if (ck_next == acc_sum) begin
                cfg_bits  <= shadow;
                fabric_en <= 1'b1;
                cfg_done  <= 1'b1;
                state     <= DONE;
              end else begin
                cfg_err <= 1'b1;
                state   <= ERROR;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
